// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - command FIFO and issue stage feeding a combinational ALU
//
// Commands arrive on cmd_valid/cmd_ready with operands cmd_a, cmd_b and opcode
// cmd_op, and wait in a DEPTH-entry FIFO. The issue FSM drives one command at a
// time onto alu_a/alu_b/alu_op, captures alu_r a cycle later and presents it on
// res_valid/res_ready as res_data/res_op. count is the FIFO occupancy and does
// not include the command currently on the ALU or waiting in the result stage.
// clk/rst_n: rising-edge clock, asynchronous active-low reset.
// Optional: define ALU_FLAGS_EN to add res_zero/res_neg, registered with res_data.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 4,
    parameter int OPW   = 4,
    parameter int RW    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [DW-1:0]          cmd_a,
    input  logic [DW-1:0]          cmd_b,
    input  logic [OPW-1:0]         cmd_op,
    output logic [DW-1:0]          alu_a,
    output logic [DW-1:0]          alu_b,
    output logic [OPW-1:0]         alu_op,
    input  logic [RW-1:0]          alu_r,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [RW-1:0]          res_data,
    output logic [OPW-1:0]         res_op,
`ifdef ALU_FLAGS_EN
    output logic                   res_zero,
    output logic                   res_neg,
`endif
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * DW + OPW;
    localparam logic [AW:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [DW-1:0]  head_a;
    logic [DW-1:0]  head_b;
    logic [OPW-1:0] head_op;
    logic           push;
    logic           pop;
    logic           capture;
    logic           release_res;

    // Ready depends only on registered occupancy; a full queue never accepts,
    // even if the issue stage pops on the same edge.
    assign cmd_ready = (count != FULL_COUNT);
    assign push      = cmd_valid && cmd_ready;

    assign {head_a, head_b, head_op} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                // The ALU has had a full cycle to settle on the loaded operands.
                capture    = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    // Back-to-back issue: reload straight from the queue.
                    if (count != '0) begin
                        pop        = 1'b1;
                        state_next = DRIVE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ALU operands hold their last loaded value; only a pop changes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else if (pop) begin
            alu_a  <= head_a;
            alu_b  <= head_b;
            alu_op <= head_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
`ifdef ALU_FLAGS_EN
            res_zero  <= 1'b0;
            res_neg   <= 1'b0;
`endif
        end else begin
            if (capture) begin
                res_valid <= 1'b1;
                res_data  <= alu_r;
                res_op    <= alu_op;
`ifdef ALU_FLAGS_EN
                res_zero  <= (alu_r == '0);
                res_neg   <= alu_r[RW-1];
`endif
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - self-checking bench for alu_issue_queue with a multiplier stub ALU
module tb_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 4;
    localparam int OPW   = 4;
    localparam int RW    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [DW-1:0]  cmd_a = '0;
    logic [DW-1:0]  cmd_b = '0;
    logic [OPW-1:0] cmd_op = '0;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_op;
    logic [RW-1:0]  alu_r;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [RW-1:0]  res_data;
    logic [OPW-1:0] res_op;
    logic [CW-1:0]  count;
`ifdef ALU_FLAGS_EN
    logic           res_zero;
    logic           res_neg;
`endif

    alu_issue_queue #(
        .DEPTH(DEPTH),
        .DW   (DW),
        .OPW  (OPW),
        .RW   (RW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .cmd_op   (cmd_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_r    (alu_r),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_op   (res_op),
`ifdef ALU_FLAGS_EN
        .res_zero (res_zero),
        .res_neg  (res_neg),
`endif
        .count    (count)
    );

    always #5 clk = ~clk;

    // Stub ALU: R = A*B, zero-extended to 8 bits
    assign alu_r = {4'b0000, alu_a} * {4'b0000, alu_b};

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic [7:0] r;
    } vec_t;

    vec_t tbl[6];
    vec_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Offer one command for one edge; record it as expected if it was accepted.
    task automatic offer(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        logic rdy;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        rdy = cmd_ready;
        tick();
        cmd_valid = 1'b0;
        if (rdy) expq.push_back('{a, b, op, 8'(a) * 8'(b)});
    endtask

    // Collect n results from expq order, requiring 2-cycle spacing between them.
    task automatic drain(input string tag, input int n);
        int   got;
        int   last;
        vec_t e;
        got = 0;
        last = -1;
        for (int c = 0; c < 40 && got < n; c++) begin
            if (res_valid) begin
                if (expq.size() == 0) begin
                    check({tag, "_unexpected_result"}, 32'(res_data), 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    check({tag, "_data"}, 32'(res_data), 32'(e.r));
                    check({tag, "_op"}, 32'(res_op), 32'(e.op));
                end
                if (last >= 0) check({tag, "_spacing"}, c - last, 2);
                last = c;
                got++;
            end
            tick();
        end
        check({tag, "_result_count"}, got, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic rdy;
        vec_t mq[$];
        vec_t cur;
        vec_t newcmd;
        int   stage;
        bit   acc;
        bit   take;

        tbl[0] = '{4'd7,  4'd5,  4'd3,  8'h23};
        tbl[1] = '{4'd0,  4'd9,  4'd1,  8'h00};
        tbl[2] = '{4'd15, 4'd15, 4'd2,  8'hE1};
        tbl[3] = '{4'd3,  4'd4,  4'd9,  8'h0C};
        tbl[4] = '{4'd1,  4'd15, 4'd15, 8'h0F};
        tbl[5] = '{4'd8,  4'd2,  4'd0,  8'h10};

        // Reset state, before any clock edge
        #1;
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_count", 32'(count), 0);
        check("rst_alu_a", 32'(alu_a), 0);
        check("rst_res_data", 32'(res_data), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single commands into an empty queue: latency 2 edges, one-cycle result
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            cmd_a = tbl[i].a;
            cmd_b = tbl[i].b;
            cmd_op = tbl[i].op;
            tick();
            cmd_valid = 1'b0;
            check("t_count_after_push", 32'(count), 1);
            tick();
            check("t_valid_early", 32'(res_valid), 0);
            check("t_alu_a", 32'(alu_a), 32'(tbl[i].a));
            check("t_alu_op", 32'(alu_op), 32'(tbl[i].op));
            tick();
            check("t_valid", 32'(res_valid), 1);
            check("t_data", 32'(res_data), 32'(tbl[i].r));
            check("t_op", 32'(res_op), 32'(tbl[i].op));
`ifdef ALU_FLAGS_EN
            check("t_zero", 32'(res_zero), 32'(tbl[i].r == 8'h00));
            check("t_neg", 32'(res_neg), 32'(tbl[i].r[7]));
`endif
            tick();
            check("t_valid_one_cycle", 32'(res_valid), 0);
            check("t_data_held", 32'(res_data), 32'(tbl[i].r));
            check("t_count_idle", 32'(count), 0);
        end

        // Fill with backpressure: 1 in HOLD + 4 queued, then stall
        res_ready = 1'b0;
        expq.delete();
        for (int c = 0; c < 12; c++) begin
            offer(4'(expq.size() + 1), 4'(expq.size() + 2), 4'(expq.size()));
        end
        check("fill_accepted", expq.size(), 5);
        check("fill_count", 32'(count), 4);
        check("fill_cmd_ready", 32'(cmd_ready), 0);
        for (int c = 0; c < 10; c++) begin
            check("hold_valid", 32'(res_valid), 1);
            check("hold_data", 32'(res_data), 32'h02);
            check("hold_op", 32'(res_op), 0);
            tick();
        end

        // Drain in push order
        res_ready = 1'b1;
        drain("drain", 5);
        check("drain_count", 32'(count), 0);
        check("drain_valid", 32'(res_valid), 0);
        tick();
        tick();
        check("drain_idle_valid", 32'(res_valid), 0);

        // Push on the same edge as a HOLD->DRIVE pop at count=2
        res_ready = 1'b0;
        expq.delete();
        offer(4'd2, 4'd3, 4'd4);
        offer(4'd4, 4'd5, 4'd6);
        offer(4'd6, 4'd7, 4'd8);
        check("simul_pre_count", 32'(count), 2);
        check("simul_pre_valid", 32'(res_valid), 1);
        check("simul_pre_data", 32'(res_data), 32'h06);
        void'(expq.pop_front());
        res_ready = 1'b1;
        offer(4'd9, 4'd9, 4'd1);
        check("simul_count", 32'(count), 2);
        check("simul_valid", 32'(res_valid), 0);
        check("simul_alu_a", 32'(alu_a), 4);
        drain("simul", 3);
        check("simul_end_count", 32'(count), 0);

        // Asynchronous reset while a result is held and the FIFO is non-empty
        res_ready = 1'b0;
        expq.delete();
        offer(4'd0, 4'd9, 4'd5);
        offer(4'd3, 4'd3, 4'd3);
        tick();
        check("hrst_pre_valid", 32'(res_valid), 1);
        check("hrst_pre_count", 32'(count), 1);
`ifdef ALU_FLAGS_EN
        check("hrst_zero", 32'(res_zero), 1);
        check("hrst_neg", 32'(res_neg), 0);
`endif
        #3;
        rst_n = 1'b0;
        #1;
        check("hrst_valid", 32'(res_valid), 0);
        check("hrst_count", 32'(count), 0);
        check("hrst_cmd_ready", 32'(cmd_ready), 1);
        check("hrst_alu_a", 32'(alu_a), 0);
        check("hrst_alu_b", 32'(alu_b), 0);
        check("hrst_alu_op", 32'(alu_op), 0);
        check("hrst_res_op", 32'(res_op), 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("hrst_post_count", 32'(count), 0);
        check("hrst_post_valid", 32'(res_valid), 0);
        expq.delete();

        // Randomized traffic against a queue-based reference model
        do_reset();
        stage = 0;
        cur = '{4'd0, 4'd0, 4'd0, 8'd0};
        for (int c = 0; c < 400; c++) begin
            cmd_valid = ($urandom_range(0, 9) < 6);
            cmd_a = 4'($urandom);
            cmd_b = 4'($urandom);
            cmd_op = 4'($urandom);
            res_ready = ($urandom_range(0, 1) == 1);
            newcmd = '{cmd_a, cmd_b, cmd_op, 8'(cmd_a) * 8'(cmd_b)};
            acc = cmd_valid && (mq.size() != DEPTH);
            // stage: 0 = nothing issued, 1 = ALU settling, 2 = result presented
            take = ((stage == 0) || (stage == 2 && res_ready)) && (mq.size() > 0);
            if (take) begin
                cur = mq.pop_front();
                stage = 1;
            end else if (stage == 1) begin
                stage = 2;
            end else if (stage == 2 && res_ready) begin
                stage = 0;
            end
            if (acc) mq.push_back(newcmd);
            tick();
            check("rnd_count", 32'(count), mq.size());
            check("rnd_cmd_ready", 32'(cmd_ready), 32'(mq.size() != DEPTH));
            check("rnd_valid", 32'(res_valid), 32'(stage == 2));
            check("rnd_alu_a", 32'(alu_a), 32'(cur.a));
            check("rnd_alu_b", 32'(alu_b), 32'(cur.b));
            check("rnd_alu_op", 32'(alu_op), 32'(cur.op));
            if (stage == 2) begin
                check("rnd_data", 32'(res_data), 32'(cur.r));
                check("rnd_op", 32'(res_op), 32'(cur.op));
            end
        end

        cmd_valid = 1'b0;
        rdy = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
